// File: rtl/axil_reg_arbiter_if.sv
// AXI4-Lite master-side channel bundle for the two-requester register arbiter.
// The arbiter drives the bus through the master modport; a slave model or fabric uses the slave modport.
interface axil_reg_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axil_reg_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI4-Lite master port.
// One transaction in flight at a time; every bus-facing VALID/READY comes straight from a flop.
module axil_reg_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [1:0]                        req_valid,
  input  logic [1:0]                        req_we,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*(C_M_AXI_DATA_WIDTH/8)-1:0] req_wstrb,
  output logic [1:0]                        req_ready,
  output logic [1:0]                        resp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     resp_rdata,
  output logic                              resp_err,
  axil_reg_arbiter_if.master                m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, DONE} state_t;

  state_t          r_state, w_state;
  logic            r_last_grant, w_last_grant;
  logic            r_grant, w_grant;
  logic [AW-1:0]   r_addr, w_addr;
  logic [DW-1:0]   r_wdata, w_wdata;
  logic [SW-1:0]   r_wstrb, w_wstrb;
  logic            r_awvalid, w_awvalid;
  logic            r_wvalid, w_wvalid;
  logic            r_bready, w_bready;
  logic            r_arvalid, w_arvalid;
  logic            r_rready, w_rready;
  logic [DW-1:0]   r_rdata, w_rdata;
  logic            r_err, w_err;
  logic [1:0]      r_req_ready, w_req_ready;
  logic [1:0]      r_resp_valid, w_resp_valid;

  logic            w_pick;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [SW-1:0]   w_sel_wstrb;
  logic            w_unused;

  // With both requesting, the one not served last time wins; otherwise the lone requester wins.
  assign w_pick      = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign w_sel_we    = w_pick ? req_we[1] : req_we[0];
  assign w_sel_addr  = w_pick ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign w_sel_wdata = w_pick ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  assign w_sel_wstrb = w_pick ? req_wstrb[2*SW-1:SW] : req_wstrb[SW-1:0];
  assign w_unused    = ^{w_sel_addr[1:0], m_axi.M_AXI_BRESP[0], m_axi.M_AXI_RRESP[0]};

  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_grant      = r_grant;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_wstrb      = r_wstrb;
    w_awvalid    = r_awvalid;
    w_wvalid     = r_wvalid;
    w_bready     = r_bready;
    w_arvalid    = r_arvalid;
    w_rready     = r_rready;
    w_rdata      = r_rdata;
    w_err        = r_err;
    w_req_ready  = 2'b00;
    w_resp_valid = 2'b00;
    case (r_state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          w_grant      = w_pick;
          w_last_grant = w_pick;
          w_req_ready  = w_pick ? 2'b10 : 2'b01;
          w_addr       = {w_sel_addr[AW-1:2], 2'b00};
          w_wdata      = w_sel_wdata;
          w_wstrb      = w_sel_wstrb;
          w_rdata      = '0;
          w_err        = 1'b0;
          if (w_sel_we) begin
            w_state   = WR;
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
          end else begin
            w_state   = RADDR;
            w_arvalid = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W complete independently; leave once neither is still pending.
        if (r_awvalid && m_axi.M_AXI_AWREADY) w_awvalid = 1'b0;
        if (r_wvalid && m_axi.M_AXI_WREADY)   w_wvalid  = 1'b0;
        if ((!r_awvalid || m_axi.M_AXI_AWREADY) && (!r_wvalid || m_axi.M_AXI_WREADY)) begin
          w_state  = WRESP;
          w_bready = 1'b1;
        end
      end
      WRESP: begin
        if (m_axi.M_AXI_BVALID) begin
          w_state      = DONE;
          w_bready     = 1'b0;
          w_err        = m_axi.M_AXI_BRESP[1];
          w_resp_valid = r_grant ? 2'b10 : 2'b01;
        end
      end
      RADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          w_state   = RDATA;
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
        end
      end
      RDATA: begin
        if (m_axi.M_AXI_RVALID) begin
          w_state      = DONE;
          w_rready     = 1'b0;
          w_rdata      = m_axi.M_AXI_RDATA;
          w_err        = m_axi.M_AXI_RRESP[1];
          w_resp_valid = r_grant ? 2'b10 : 2'b01;
        end
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_req_ready  <= 2'b00;
      r_resp_valid <= 2'b00;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_grant      <= w_grant;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_wstrb      <= w_wstrb;
      r_awvalid    <= w_awvalid;
      r_wvalid     <= w_wvalid;
      r_bready     <= w_bready;
      r_arvalid    <= w_arvalid;
      r_rready     <= w_rready;
      r_rdata      <= w_rdata;
      r_err        <= w_err;
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
    end
  end

  assign req_ready           = r_req_ready;
  assign resp_valid          = r_resp_valid;
  assign resp_rdata          = r_rdata;
  assign resp_err            = r_err;
  assign m_axi.M_AXI_AWADDR  = r_addr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = r_wstrb;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_addr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Directed bench for axil_reg_arbiter: an AXI4-Lite register slave model with tunable
// READY delays, a VALID-stability monitor, and a linear sequence of checked transactions.
module tb_axil_reg_arbiter;
  localparam int AW = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [7:0]  req_addr = 8'h00;
  logic [63:0] req_wdata = 64'h0;
  logic [7:0]  req_wstrb = 8'h00;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 ACLK = ~ACLK;

  axil_reg_arbiter_if #(.ADDR_W(AW), .DATA_W(32)) axi ();

  axil_reg_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_axi(axi)
  );

  // Slave model: READY asserts after a programmable number of VALID cycles.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit          b_hold = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int          n_b = 0, n_resp = 0, n_viol = 0;
  logic [31:0] mem [4];
  logic [3:0]  s_awaddr, s_araddr, last_awaddr, last_araddr, s_wstrb, last_wstrb;
  logic [31:0] s_wdata, last_wdata;
  bit          s_aw_got = 1'b0, s_w_got = 1'b0, s_ar_got = 1'b0;

  assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && (aw_cnt >= aw_dly);
  assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID && (w_cnt >= w_dly);
  assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && (ar_cnt >= ar_dly);

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_ar_got <= 1'b0;
      axi.M_AXI_BVALID <= 1'b0; axi.M_AXI_BRESP <= 2'b00;
      axi.M_AXI_RVALID <= 1'b0; axi.M_AXI_RRESP <= 2'b00; axi.M_AXI_RDATA <= 32'h0;
      mem[0] <= 32'h0000_1111; mem[1] <= 32'h0000_0000;
      mem[2] <= 32'h2222_2222; mem[3] <= 32'hDEAD_BEEF;
    end else begin
      if (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) aw_cnt <= aw_cnt + 1;
      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        aw_cnt <= 0; s_awaddr <= axi.M_AXI_AWADDR; last_awaddr <= axi.M_AXI_AWADDR; s_aw_got <= 1'b1;
      end
      if (axi.M_AXI_WVALID && !axi.M_AXI_WREADY) w_cnt <= w_cnt + 1;
      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        w_cnt <= 0; s_wdata <= axi.M_AXI_WDATA; s_wstrb <= axi.M_AXI_WSTRB; s_w_got <= 1'b1;
        last_wdata <= axi.M_AXI_WDATA; last_wstrb <= axi.M_AXI_WSTRB;
      end
      if (s_aw_got && s_w_got && !axi.M_AXI_BVALID && !b_hold) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) mem[s_awaddr[3:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        axi.M_AXI_BVALID <= 1'b1; axi.M_AXI_BRESP <= 2'b00;
        s_aw_got <= 1'b0; s_w_got <= 1'b0;
      end
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
        axi.M_AXI_BVALID <= 1'b0; n_b <= n_b + 1;
      end
      if (axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY) ar_cnt <= ar_cnt + 1;
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        ar_cnt <= 0; s_araddr <= axi.M_AXI_ARADDR; last_araddr <= axi.M_AXI_ARADDR; s_ar_got <= 1'b1;
      end
      if (s_ar_got && !axi.M_AXI_RVALID) begin
        axi.M_AXI_RVALID <= 1'b1;
        axi.M_AXI_RDATA  <= mem[s_araddr[3:2]];
        axi.M_AXI_RRESP  <= (s_araddr == 4'hC) ? 2'b10 : 2'b00;
        s_ar_got <= 1'b0;
      end
      if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) axi.M_AXI_RVALID <= 1'b0;
    end
  end

  // Protocol monitor: a pending VALID must stay high, and AWVALID/WVALID must rise together.
  logic p_aw_pend = 1'b0, p_w_pend = 1'b0, p_ar_pend = 1'b0, p_awv = 1'b0, p_wv = 1'b0;
  always @(posedge ACLK) begin
    if (ARESET) begin
      p_aw_pend <= 1'b0; p_w_pend <= 1'b0; p_ar_pend <= 1'b0; p_awv <= 1'b0; p_wv <= 1'b0;
    end else begin
      if ((p_aw_pend && !axi.M_AXI_AWVALID) || (p_w_pend && !axi.M_AXI_WVALID) ||
          (p_ar_pend && !axi.M_AXI_ARVALID) ||
          (!p_awv && !p_wv && (axi.M_AXI_AWVALID != axi.M_AXI_WVALID)))
        n_viol <= n_viol + 1;
      p_aw_pend <= axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY;
      p_w_pend  <= axi.M_AXI_WVALID && !axi.M_AXI_WREADY;
      p_ar_pend <= axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY;
      p_awv     <= axi.M_AXI_AWVALID;
      p_wv      <= axi.M_AXI_WVALID;
    end
  end

  always @(negedge ACLK) if (resp_valid != 2'b00) n_resp <= n_resp + 1;

  int n_cmp = 0, n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input bit r, input logic we, input logic [3:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws,
                           output logic [1:0] rv, output logic [31:0] rd,
                           output logic er, output logic ok);
    int t;
    @(negedge ACLK);
    if (r) begin
      req_we[1] = we; req_addr[7:4] = addr; req_wdata[63:32] = wd; req_wstrb[7:4] = ws; req_valid[1] = 1'b1;
    end else begin
      req_we[0] = we; req_addr[3:0] = addr; req_wdata[31:0] = wd; req_wstrb[3:0] = ws; req_valid[0] = 1'b1;
    end
    t = 0;
    while (req_ready == 2'b00 && t < 50) begin @(negedge ACLK); t++; end
    req_valid = 2'b00;
    while (resp_valid == 2'b00 && t < 300) begin @(negedge ACLK); t++; end
    rv = resp_valid; rd = resp_rdata; er = resp_err; ok = (resp_valid != 2'b00);
  endtask

  logic [1:0]  rv;
  logic [31:0] rd;
  logic        er, ok;
  logic [7:0]  gseq;
  int          ng, t, nb0, nr0;

  initial begin
    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_axi_valid_ready", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                                      axi.M_AXI_BREADY, axi.M_AXI_RREADY}), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    ARESET = 1'b0;

    // Contention: both requesters hold reads continuously; grants must alternate from requester 0
    @(negedge ACLK);
    nr0 = n_resp;
    req_we = 2'b00; req_addr = 8'h80; req_valid = 2'b11;
    gseq = 8'h00; ng = 0; t = 0;
    while (ng < 8 && t < 400) begin
      @(negedge ACLK); t++;
      if (req_ready != 2'b00) begin gseq[ng] = req_ready[1]; ng++; end
    end
    req_valid = 2'b00;
    while (resp_valid == 2'b00 && t < 500) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    check("cont_grant_count", 64'(ng), 64'd8);
    check("cont_grant_seq", 64'(gseq), 64'hAA);
    check("cont_resp_count", 64'(n_resp - nr0), 64'd8);

    // Single write then read from requester 0
    do_access(1'b0, 1'b1, 4'h4, 32'h0000_00A5, 4'hF, rv, rd, er, ok);
    check("wr_done", 64'(ok), 64'd1);
    check("wr_resp_valid", 64'(rv), 64'h1);
    check("wr_rdata_zero", 64'(rd), 64'd0);
    check("wr_err", 64'(er), 64'd0);
    check("wr_awaddr", 64'(last_awaddr), 64'h4);
    check("wr_wdata", 64'(last_wdata), 64'hA5);
    check("wr_wstrb", 64'(last_wstrb), 64'hF);
    do_access(1'b0, 1'b0, 4'h4, 32'h0, 4'h0, rv, rd, er, ok);
    check("rd_done", 64'(ok), 64'd1);
    check("rd_resp_valid", 64'(rv), 64'h1);
    check("rd_rdata", 64'(rd), 64'hA5);
    check("rd_err", 64'(er), 64'd0);

    // Handshake ordering: W before AW, AW before W, then together
    nb0 = n_b; aw_dly = 3; w_dly = 0;
    do_access(1'b0, 1'b1, 4'h8, 32'h1234_5678, 4'hF, rv, rd, er, ok);
    repeat (2) @(negedge ACLK);
    check("ord_w_first_done", 64'(ok), 64'd1);
    check("ord_w_first_b", 64'(n_b - nb0), 64'd1);
    nb0 = n_b; aw_dly = 0; w_dly = 3;
    do_access(1'b0, 1'b1, 4'h8, 32'hCAFE_0000, 4'hC, rv, rd, er, ok);
    repeat (2) @(negedge ACLK);
    check("ord_aw_first_done", 64'(ok), 64'd1);
    check("ord_aw_first_b", 64'(n_b - nb0), 64'd1);
    nb0 = n_b; aw_dly = 2; w_dly = 2;
    do_access(1'b1, 1'b1, 4'h0, 32'h0000_00FF, 4'h1, rv, rd, er, ok);
    repeat (2) @(negedge ACLK);
    check("ord_both_done", 64'(ok), 64'd1);
    check("ord_both_b", 64'(n_b - nb0), 64'd1);
    check("ord_both_resp_valid", 64'(rv), 64'h2);
    aw_dly = 0; w_dly = 0; ar_dly = 2;
    do_access(1'b0, 1'b0, 4'h8, 32'h0, 4'h0, rv, rd, er, ok);
    check("strb_merge_rdata", 64'(rd), 64'hCAFE_5678);
    do_access(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, rv, rd, er, ok);
    check("strb_low_byte_rdata", 64'(rd), 64'h0000_11FF);
    ar_dly = 0;

    // Read error response, then a clean access
    do_access(1'b1, 1'b0, 4'hC, 32'h0, 4'h0, rv, rd, er, ok);
    check("err_resp_valid", 64'(rv), 64'h2);
    check("err_flag", 64'(er), 64'd1);
    check("err_rdata", 64'(rd), 64'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 4'h4, 32'h0, 4'h0, rv, rd, er, ok);
    check("post_err_flag", 64'(er), 64'd0);
    check("post_err_rdata", 64'(rd), 64'hA5);

    // Address alignment
    do_access(1'b0, 1'b0, 4'h7, 32'h0, 4'h0, rv, rd, er, ok);
    check("align_araddr", 64'(last_araddr), 64'h4);
    check("align_rdata", 64'(rd), 64'hA5);

    // Reset while waiting on a withheld B response
    b_hold = 1'b1;
    @(negedge ACLK);
    req_we[0] = 1'b1; req_addr[3:0] = 4'h8; req_wdata[31:0] = 32'h5555_5555; req_wstrb[3:0] = 4'hF;
    req_valid[0] = 1'b1;
    t = 0;
    while (req_ready == 2'b00 && t < 50) begin @(negedge ACLK); t++; end
    req_valid = 2'b00;
    while (axi.M_AXI_BREADY !== 1'b1 && t < 100) begin @(negedge ACLK); t++; end
    check("mid_bready_seen", 64'(axi.M_AXI_BREADY), 64'd1);
    repeat (3) @(negedge ACLK);
    check("mid_still_waiting", 64'({axi.M_AXI_BREADY, resp_valid}), 64'h4);
    nr0 = n_resp;
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    b_hold = 1'b0;
    check("mid_rst_axi_valid_ready", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                                          axi.M_AXI_BREADY, axi.M_AXI_RREADY}), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    check("mid_rst_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
    repeat (5) @(negedge ACLK);
    check("mid_rst_no_resp", 64'(n_resp - nr0), 64'd0);
    do_access(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, rv, rd, er, ok);
    check("mid_rst_read_done", 64'(ok), 64'd1);
    check("mid_rst_read_rv", 64'(rv), 64'h1);
    check("mid_rst_read_rdata", 64'(rd), 64'h0000_1111);
    check("mid_rst_read_err", 64'(er), 64'd0);

    repeat (2) @(negedge ACLK);
    check("valid_hold_violations", 64'(n_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
